// File: rtl/mos6502s_status_reg.sv
// Processor status (P) register for the mos6502s core: ALU flag capture, flag instructions,
// PLP/RTI loads, interrupt-entry I-set, SO pin, and the one-instruction-delayed IRQ mask.
module mos6502s_status_reg #(
    parameter bit RESET_I   = 1'b1,
    parameter bit SO_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic [2:0] flag_op,
    input  logic       load_p,
    input  logic [7:0] p_in,
    input  logic       set_i,
    input  logic       brk_push,
    input  logic       instr_done,
    input  logic       so_n,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       c_flag,
    output logic       d_flag,
    output logic       i_flag,
    output logic       irq_mask
);

    localparam logic [2:0] OpClc = 3'd1;
    localparam logic [2:0] OpSec = 3'd2;
    localparam logic [2:0] OpCli = 3'd3;
    localparam logic [2:0] OpSei = 3'd4;
    localparam logic [2:0] OpCld = 3'd5;
    localparam logic [2:0] OpSed = 3'd6;
    localparam logic [2:0] OpClv = 3'd7;

    logic n_q, v_q, d_q, i_q, z_q, c_q, irq_q, so_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d, irq_d;
    logic so_edge;

    // Falling edge of the already-synchronised SO pin; a held-low pin fires only once.
    assign so_edge = SO_ENABLE && so_q && !so_n;

    always_comb begin
        n_d   = n_q;
        v_d   = v_q;
        d_d   = d_q;
        i_d   = i_q;
        z_d   = z_q;
        c_d   = c_q;
        irq_d = irq_q;

        if (load_p) begin
            n_d = p_in[7];
            z_d = p_in[1];
        end else if (upd_nz) begin
            n_d = alu_n;
            z_d = alu_z;
        end

        if (load_p)                c_d = p_in[0];
        else if (flag_op == OpClc) c_d = 1'b0;
        else if (flag_op == OpSec) c_d = 1'b1;
        else if (upd_c)            c_d = alu_c;

        if (load_p)                d_d = p_in[3];
        else if (flag_op == OpCld) d_d = 1'b0;
        else if (flag_op == OpSed) d_d = 1'b1;

        if (set_i)                 i_d = 1'b1;
        else if (load_p)           i_d = p_in[2];
        else if (flag_op == OpCli) i_d = 1'b0;
        else if (flag_op == OpSei) i_d = 1'b1;

        if (so_edge)               v_d = 1'b1;
        else if (load_p)           v_d = p_in[6];
        else if (flag_op == OpClv) v_d = 1'b0;
        else if (upd_v)            v_d = alu_v;

        // Boundary samples the pre-update I, so an I write landing on the boundary is seen late.
        if (set_i)           irq_d = 1'b1;
        else if (instr_done) irq_d = i_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q   <= 1'b0;
            v_q   <= 1'b0;
            d_q   <= 1'b0;
            i_q   <= RESET_I;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            irq_q <= RESET_I;
            so_q  <= 1'b1;
        end else begin
            n_q   <= n_d;
            v_q   <= v_d;
            d_q   <= d_d;
            i_q   <= i_d;
            z_q   <= z_d;
            c_q   <= c_d;
            irq_q <= irq_d;
            so_q  <= so_n;
        end
    end

    assign p_out    = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
    assign p_push   = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
    assign c_flag   = c_q;
    assign d_flag   = d_q;
    assign i_flag   = i_q;
    assign irq_mask = irq_q;

endmodule

// File: tb/tb_mos6502s_status_reg.sv
// Directed bench for mos6502s_status_reg; a second instance with SO_ENABLE=0 shares the stimulus.
module tb_mos6502s_status_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic       upd_nz, upd_c, upd_v;
    logic [2:0] flag_op;
    logic       load_p;
    logic [7:0] p_in;
    logic       set_i, brk_push, instr_done, so_n;

    logic [7:0] p_out, p_push, p_out2, p_push2;
    logic       c_flag, d_flag, i_flag, irq_mask;
    logic       c_flag2, d_flag2, i_flag2, irq_mask2;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mos6502s_status_reg #(.RESET_I(1'b1), .SO_ENABLE(1'b1)) dut (
        .clk(clk), .rst(rst), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .flag_op(flag_op), .load_p(load_p),
        .p_in(p_in), .set_i(set_i), .brk_push(brk_push), .instr_done(instr_done),
        .so_n(so_n), .p_out(p_out), .p_push(p_push), .c_flag(c_flag), .d_flag(d_flag),
        .i_flag(i_flag), .irq_mask(irq_mask)
    );

    mos6502s_status_reg #(.RESET_I(1'b1), .SO_ENABLE(1'b0)) dut_noso (
        .clk(clk), .rst(rst), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .flag_op(flag_op), .load_p(load_p),
        .p_in(p_in), .set_i(set_i), .brk_push(brk_push), .instr_done(instr_done),
        .so_n(so_n), .p_out(p_out2), .p_push(p_push2), .c_flag(c_flag2), .d_flag(d_flag2),
        .i_flag(i_flag2), .irq_mask(irq_mask2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        {alu_n, alu_z, alu_c, alu_v, upd_nz, upd_c, upd_v} = '0;
        flag_op = 3'd0; set_i = 1'b0; brk_push = 1'b0; instr_done = 1'b0; so_n = 1'b1;

        // Reset overrides a simultaneous load
        rst = 1'b1; load_p = 1'b1; p_in = 8'hFF;
        tick();
        chk("reset_p_out", p_out, 8'h34);
        chk("reset_irq_mask", {7'd0, irq_mask}, 8'h01);
        chk("reset_c_flag", {7'd0, c_flag}, 8'h00);
        chk("reset_d_flag", {7'd0, d_flag}, 8'h00);
        chk("reset_noso_p_out", p_out2, 8'h34);
        rst = 1'b0; load_p = 1'b0; p_in = 8'h00;

        // ALU capture, V not enabled
        alu_n = 1'b1; alu_z = 1'b0; alu_c = 1'b1; alu_v = 1'b1;
        upd_nz = 1'b1; upd_c = 1'b1; upd_v = 1'b0;
        tick();
        chk("alu_capture", p_out, 8'hB5);
        alu_n = 1'b0; alu_z = 1'b1; alu_c = 1'b0; alu_v = 1'b0;
        upd_nz = 1'b0; upd_c = 1'b0;
        tick();
        chk("alu_hold", p_out, 8'hB5);

        // Priority
        flag_op = 3'd1; upd_c = 1'b1; alu_c = 1'b1;
        tick();
        chk("clc_over_upd_c", p_out, 8'hB4);
        upd_c = 1'b0; load_p = 1'b1; p_in = 8'h01;
        tick();
        chk("load_over_clc", p_out, 8'h31);
        chk("load_c_flag", {7'd0, c_flag}, 8'h01);
        flag_op = 3'd0; set_i = 1'b1; p_in = 8'h00;
        tick();
        chk("set_i_over_load", p_out, 8'h34);
        chk("set_i_irq_mask", {7'd0, irq_mask}, 8'h01);

        // PLP and push format
        set_i = 1'b0; p_in = 8'hCF;
        tick();
        chk("plp_p_out", p_out, 8'hFF);
        chk("plp_d_flag", {7'd0, d_flag}, 8'h01);
        load_p = 1'b0; p_in = 8'h00; brk_push = 1'b0;
        #1;
        chk("push_brk0", p_push, 8'hEF);
        brk_push = 1'b1;
        #1;
        chk("push_brk1", p_push, 8'hFF);
        brk_push = 1'b0;

        // IRQ mask delay
        flag_op = 3'd3; instr_done = 1'b1;
        tick();
        chk("cli_i_flag", {7'd0, i_flag}, 8'h00);
        chk("cli_mask_late", {7'd0, irq_mask}, 8'h01);
        flag_op = 3'd0;
        tick();
        chk("mask_next_boundary", {7'd0, irq_mask}, 8'h00);
        flag_op = 3'd4; instr_done = 1'b0;
        tick();
        chk("sei_i_flag", {7'd0, i_flag}, 8'h01);
        chk("sei_mask_held", {7'd0, irq_mask}, 8'h00);
        flag_op = 3'd0; instr_done = 1'b1;
        tick();
        chk("sei_mask_boundary", {7'd0, irq_mask}, 8'h01);
        instr_done = 1'b0;
        flag_op = 3'd5;
        tick();
        chk("cld_d_flag", {7'd0, d_flag}, 8'h00);

        // SO pin: clear V first, then hold so_n low 5 cycles with CLV on the third
        flag_op = 3'd7;
        tick();
        chk("clv_before_so", {7'd0, p_out[6]}, 8'h00);
        flag_op = 3'd0;
        so_n = 1'b0;
        tick();
        chk("so_edge_sets_v", {7'd0, p_out[6]}, 8'h01);
        chk("noso_v_c1", {7'd0, p_out2[6]}, 8'h00);
        tick();
        chk("so_held_v", {7'd0, p_out[6]}, 8'h01);
        flag_op = 3'd7;
        tick();
        chk("so_clv_c3", {7'd0, p_out[6]}, 8'h00);
        flag_op = 3'd0;
        tick();
        chk("so_stays_clear_c4", {7'd0, p_out[6]}, 8'h00);
        tick();
        chk("so_stays_clear_c5", {7'd0, p_out[6]}, 8'h00);
        chk("noso_v_c5", {7'd0, p_out2[6]}, 8'h00);
        so_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
